// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction word geometry, field bit positions,
// program-load FSM states and the word packing helper used by the encoder.
package isa_pkg;

    localparam int unsigned INSTR_W   = 20;
    localparam int unsigned OPC_W     = 4;
    localparam int unsigned OPERAND_W = 8;
    localparam int unsigned REG_W     = 3;

    // Field positions, shared with the ID-stage decoder
    localparam int unsigned OPC_HI = 19;
    localparam int unsigned OPC_LO = 16;
    localparam int unsigned A_HI   = 15;
    localparam int unsigned A_LO   = 8;
    localparam int unsigned B_HI   = 7;
    localparam int unsigned B_LO   = 0;
    localparam int unsigned RS_LO  = 8;
    localparam int unsigned RT_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_t;

    // Reg mode places rs/rt in the low bits of the operand slots; rd is implicitly rs
    function automatic logic [INSTR_W-1:0] pack_word(
        input logic                 reg_mode,
        input logic [OPC_W-1:0]     opcode,
        input logic [OPERAND_W-1:0] a,
        input logic [OPERAND_W-1:0] b,
        input logic [REG_W-1:0]     rs,
        input logic [REG_W-1:0]     rt
    );
        logic [INSTR_W-1:0] w;
        w = '0;
        w[OPC_HI:OPC_LO] = opcode;
        if (reg_mode) begin
            w[RS_LO +: REG_W] = rs;
            w[RT_LO +: REG_W] = rt;
        end else begin
            w[A_HI:A_LO] = a;
            w[B_HI:B_LO] = b;
        end
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle stream (valid/ready) plus instruction-memory write port.
// slave : the encoder (consumes bundles, drives the imem write port)
// master: the producer / memory side
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 6
);
    import isa_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic                 in_reg_mode;
    logic [OPC_W-1:0]     in_opcode;
    logic [OPERAND_W-1:0] in_a;
    logic [OPERAND_W-1:0] in_b;
    logic [REG_W-1:0]     in_rs;
    logic [REG_W-1:0]     in_rt;
    logic                 imem_stall;
    logic                 imem_we;
    logic [ADDR_W-1:0]    imem_addr;
    logic [INSTR_W-1:0]   imem_wdata;

    modport slave (
        input  in_valid, in_last, in_reg_mode, in_opcode, in_a, in_b, in_rs, in_rt,
        output in_ready,
        input  imem_stall,
        output imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, in_last, in_reg_mode, in_opcode, in_a, in_b, in_rs, in_rt,
        input  in_ready,
        output imem_stall,
        input  imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, synchronous active-low reset.
// Ports: i_push/i_wdata write side, i_pop/o_rdata read side (o_rdata is the
// current head), o_full/o_empty level flags. Push when full / pop when empty
// are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// Program-load engine: packs opcode/operand bundles into 20-bit words and
// streams them into instruction memory at auto-incrementing addresses.
// Ports: clk, rst_n (sync, active-low), start (begin load at addr 0),
// bus (field stream in / imem write port out), busy (LOAD or FLUSH),
// done (one-cycle completion pulse), overflow (sticky word drop),
// word_count (words written this load, saturating at 2**ADDR_W).
module instr_encoder
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    instr_encoder_if.slave  bus,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [ADDR_W:0] word_count
);
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    enc_state_t          r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;
    logic [ADDR_W:0]     r_word_count;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [INSTR_W-1:0]  r_wdata;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_start_load;
    logic [INSTR_W-1:0]  w_word;
    logic [INSTR_W-1:0]  w_head;

    assign w_word = pack_word(bus.in_reg_mode, bus.in_opcode, bus.in_a, bus.in_b,
                              bus.in_rs, bus.in_rt);

    // Ready depends only on state and FIFO level; no bypass when full
    assign bus.in_ready  = (r_state == ST_LOAD) && !w_full;
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = !w_empty && !bus.imem_stall;
    assign w_start_load  = start && (r_state == ST_IDLE);

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Load-sequencing FSM with registered busy/done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_push && bus.in_last) r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    // Wait until the last popped word has left the output register
                    if (w_empty && !r_we) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Write issue: word_count doubles as the address counter, so it never wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_start_load) begin
                r_word_count <= '0;
                r_overflow   <= 1'b0;
            end
            if (w_pop) begin
                if (r_word_count == CAP) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_we         <= 1'b1;
                    r_addr       <= r_word_count[ADDR_W-1:0];
                    r_wdata      <= w_head;
                    r_word_count <= r_word_count + (ADDR_W+1)'(1);
                end
            end
        end
    end

    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign busy           = r_busy;
    assign done           = r_done;
    assign overflow       = r_overflow;
    assign word_count     = r_word_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (64-word and 4-word memories) share
// one stimulus stream; a queue of accepted words is the reference program.
module tb_instr_encoder;

    typedef struct {
        int unsigned addr;
        int unsigned data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic        reg_mode;
        logic [3:0]  opc;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [19:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    logic start;
    logic in_valid, in_last, in_reg_mode, imem_stall;
    logic [3:0] in_opcode;
    logic [7:0] in_a, in_b;
    logic [2:0] in_rs, in_rt;
    logic busy6, done6, ovf6, busy2, done2, ovf2;
    logic [6:0] wc6;
    logic [2:0] wc2;

    int unsigned acc_q[$];
    wr_t wr6_q[$];
    wr_t wr2_q[$];
    int done6_cnt, done2_cnt, cyc;
    int n_chk, n_pass;
    bit rnd_stall;

    instr_encoder_if #(.ADDR_W(6)) if6();
    instr_encoder_if #(.ADDR_W(2)) if2();

    assign if6.in_valid = in_valid;     assign if2.in_valid = in_valid;
    assign if6.in_last = in_last;       assign if2.in_last = in_last;
    assign if6.in_reg_mode = in_reg_mode; assign if2.in_reg_mode = in_reg_mode;
    assign if6.in_opcode = in_opcode;   assign if2.in_opcode = in_opcode;
    assign if6.in_a = in_a;             assign if2.in_a = in_a;
    assign if6.in_b = in_b;             assign if2.in_b = in_b;
    assign if6.in_rs = in_rs;           assign if2.in_rs = in_rs;
    assign if6.in_rt = in_rt;           assign if2.in_rt = in_rt;
    assign if6.imem_stall = imem_stall; assign if2.imem_stall = imem_stall;

    instr_encoder #(.ADDR_W(6), .FIFO_DEPTH(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(if6.slave),
        .busy(busy6), .done(done6), .overflow(ovf6), .word_count(wc6));

    instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(if2.slave),
        .busy(busy2), .done(done2), .overflow(ovf2), .word_count(wc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference packing: opcode in the top nibble, operands as byte lanes
    function automatic int unsigned model_word(logic rm, logic [3:0] opc, logic [7:0] a,
                                               logic [7:0] b, logic [2:0] rs, logic [2:0] rt);
        if (rm) return int'(opc) * 65536 + int'(rs) * 256 + int'(rt);
        return int'(opc) * 65536 + int'(a) * 256 + int'(b);
    endfunction

    always @(posedge clk) begin
        wr_t w;
        cyc++;
        if (rst_n && in_valid && if6.in_ready)
            acc_q.push_back(model_word(in_reg_mode, in_opcode, in_a, in_b, in_rs, in_rt));
        if (if6.imem_we) begin
            w.addr = if6.imem_addr; w.data = if6.imem_wdata; w.cyc = cyc;
            wr6_q.push_back(w);
        end
        if (if2.imem_we) begin
            w.addr = if2.imem_addr; w.data = if2.imem_wdata; w.cyc = cyc;
            wr2_q.push_back(w);
        end
        if (done6) done6_cnt++;
        if (done2) done2_cnt++;
    end

    always @(negedge clk) if (rnd_stall) imem_stall = ($urandom_range(0, 3) == 0);

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        acc_q.delete(); wr6_q.delete(); wr2_q.delete();
        done6_cnt = 0; done2_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drive(input logic rm, input logic [3:0] opc, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] rs, input logic [2:0] rt,
                         input logic last);
        in_reg_mode = rm; in_opcode = opc; in_a = a; in_b = b;
        in_rs = rs; in_rt = rt; in_last = last; in_valid = 1'b1;
    endtask

    // Offer one bundle and hold it until a clock edge accepts it
    task automatic send(input logic rm, input logic [3:0] opc, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] rs, input logic [2:0] rt,
                        input logic last);
        bit t, ok;
        int budget;
        ok = 0; budget = 0;
        drive(rm, opc, a, b, rs, rt, last);
        while (!ok && budget < 60) begin
            t = if6.in_ready;
            step();
            budget++;
            if (t) ok = 1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while (done6_cnt == 0 && b < 400) begin
            step();
            b++;
        end
        chk("done_seen", done6_cnt > 0, 1);
        step();
        step();
    endtask

    task automatic check_one(input string tag, input wr_t q[$], input int cap,
                             input logic ovf, input int wc, input int dcnt, input logic bsy);
        int n, exp_n;
        n = acc_q.size();
        exp_n = (n < cap) ? n : cap;
        chk({tag, "_nwrites"}, q.size(), exp_n);
        for (int i = 0; i < exp_n && i < q.size(); i++) begin
            chk({tag, "_addr"}, q[i].addr, i);
            chk({tag, "_data"}, q[i].data, acc_q[i]);
        end
        chk({tag, "_overflow"}, ovf, (n > cap) ? 1 : 0);
        chk({tag, "_word_count"}, wc, exp_n);
        chk({tag, "_done_pulses"}, dcnt, 1);
        chk({tag, "_busy_after"}, bsy, 0);
    endtask

    task automatic check_load();
        check_one("a6", wr6_q, 64, ovf6, int'(wc6), done6_cnt, busy6);
        check_one("a2", wr2_q, 4, ovf2, int'(wc2), done2_cnt, busy2);
    endtask

    initial begin
        vec_t vecs[6];
        int d;
        vecs[0] = '{1'b0, 4'h1, 8'hAB, 8'hCD, 3'd0, 3'd0, 20'h1ABCD};
        vecs[1] = '{1'b1, 4'h2, 8'hFF, 8'hFF, 3'd3, 3'd5, 20'h20305};
        vecs[2] = '{1'b0, 4'hF, 8'h00, 8'hFF, 3'd7, 3'd7, 20'hF00FF};
        vecs[3] = '{1'b1, 4'h7, 8'h12, 8'h34, 3'd7, 3'd0, 20'h70700};
        vecs[4] = '{1'b0, 4'h0, 8'h5A, 8'hA5, 3'd2, 3'd1, 20'h05AA5};
        vecs[5] = '{1'b1, 4'hA, 8'hC3, 8'h3C, 3'd1, 3'd6, 20'hA0106};

        n_chk = 0; n_pass = 0; cyc = 0; rnd_stall = 0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_reg_mode = 1'b0;
        in_opcode = '0; in_a = '0; in_b = '0; in_rs = '0; in_rt = '0; imem_stall = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_we", if6.imem_we, 0);
        chk("rst_done", done6, 0);
        chk("rst_overflow", ovf6, 0);
        chk("rst_word_count", wc6, 0);
        chk("rst_busy", busy6, 0);
        chk("rst_in_ready", if6.in_ready, 0);
        chk("rst_addr", if6.imem_addr, 0);
        chk("rst_wc2", wc2, 0);
        rst_n = 1'b1;
        step();

        // in_valid in IDLE is ignored
        drive(1'b0, 4'h9, 8'h11, 8'h22, 3'd0, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("idle_in_ready", if6.in_ready, 0);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("idle_no_accept", acc_q.size(), 0);
        chk("idle_no_write", wr6_q.size(), 0);
        chk("idle_busy", busy6, 0);

        // Field-mode load with best-case latency
        start_load();
        chk("load_busy", busy6, 1);
        send(1'b0, 4'h1, 8'hAB, 8'hCD, 3'd0, 3'd0, 1'b1);
        chk("lat_we_k", if6.imem_we, 0);
        step();
        chk("lat_we_k1", if6.imem_we, 1);
        chk("lat_addr", if6.imem_addr, 0);
        chk("lat_wdata", if6.imem_wdata, 20'h1ABCD);
        wait_done();
        check_load();

        // Reg-mode word and its ID-stage decode
        start_load();
        send(1'b1, 4'h2, 8'h00, 8'h00, 3'd3, 3'd5, 1'b1);
        wait_done();
        check_load();
        d = (wr6_q.size() > 0) ? int'(wr6_q[0].data) : 0;
        chk("reg_wdata", d, 20'h20305);
        chk("reg_dec_rs", (d >> 8) & 7, 3);
        chk("reg_dec_rt", d & 7, 5);
        chk("reg_dec_rd", (d >> 8) & 7, 3);

        // Packing table
        for (int i = 0; i < 6; i++) begin
            start_load();
            send(vecs[i].reg_mode, vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].rs,
                 vecs[i].rt, 1'b1);
            wait_done();
            chk($sformatf("vec%0d_nwr", i), wr6_q.size(), 1);
            if (wr6_q.size() > 0) chk($sformatf("vec%0d_wdata", i), wr6_q[0].data, vecs[i].exp);
        end

        // start during LOAD is ignored
        start_load();
        send(1'b0, 4'h4, 8'h01, 8'h02, 3'd0, 3'd0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_load_busy", busy6, 1);
        send(1'b0, 4'h5, 8'h03, 8'h04, 3'd0, 3'd0, 1'b1);
        wait_done();
        check_load();

        // Overflow: five words into the four-word memory
        start_load();
        for (int i = 0; i < 5; i++)
            send(1'b0, 4'(i + 1), 8'(i * 17), 8'(255 - i), 3'd0, 3'd0, 1'(i == 4));
        wait_done();
        check_load();
        chk("ovf2_set", ovf2, 1);
        chk("ovf2_wc", wc2, 4);
        start_load();
        chk("ovf2_cleared_on_start", ovf2, 0);
        chk("wc2_cleared_on_start", wc2, 0);
        send(1'b1, 4'h6, 8'h00, 8'h00, 3'd1, 3'd2, 1'b1);
        wait_done();
        check_load();

        // Backpressure: FIFO fills to 4 with memory stalled
        imem_stall = 1'b1;
        start_load();
        for (int i = 0; i < 4; i++)
            send(1'b0, 4'(8 + i), 8'(16 * i + 1), 8'(i), 3'd0, 3'd0, 1'b0);
        drive(1'b0, 4'hC, 8'h41, 8'h04, 3'd0, 3'd0, 1'b0);
        step(); step(); step();
        chk("bp_in_ready", if6.in_ready, 0);
        chk("bp_accepts", acc_q.size(), 4);
        chk("bp_no_writes", wr6_q.size(), 0);
        imem_stall = 1'b0;
        send(1'b0, 4'hC, 8'h41, 8'h04, 3'd0, 3'd0, 1'b0);
        send(1'b0, 4'hD, 8'h51, 8'h05, 3'd0, 3'd0, 1'b1);
        wait_done();
        check_load();
        if (wr6_q.size() == 6)
            for (int i = 1; i < 6; i++)
                chk("bp_consecutive", wr6_q[i].cyc - wr6_q[0].cyc, i);

        // Reset mid-load abandons the load
        start_load();
        send(1'b0, 4'h3, 8'h33, 8'h44, 3'd0, 3'd0, 1'b0);
        send(1'b0, 4'h3, 8'h55, 8'h66, 3'd0, 3'd0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_we", if6.imem_we, 0);
        chk("mid_rst_wc", wc6, 0);
        chk("mid_rst_busy", busy6, 0);
        chk("mid_rst_in_ready", if6.in_ready, 0);
        wr6_q.delete(); wr2_q.delete();
        repeat (5) step();
        chk("mid_rst_no_writes", wr6_q.size(), 0);
        start_load();
        send(1'b0, 4'hE, 8'h77, 8'h88, 3'd0, 3'd0, 1'b1);
        wait_done();
        check_load();

        // Randomized loads with random stalls and gaps
        rnd_stall = 1;
        for (int l = 0; l < 15; l++) begin
            int n;
            n = $urandom_range(1, 10);
            start_load();
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 2)) step();
                send(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 8'($urandom),
                     3'($urandom), 3'($urandom), 1'(j == n - 1));
            end
            wait_done();
            check_load();
        end
        rnd_stall = 0;
        imem_stall = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the ID-stage field decoder: packs opcode/operand fields into 20-bit instruction words and streams them into instruction memory as a program-load engine.
- Input is a valid/ready field stream; output is a registered imem write port with an auto-incrementing address.
- A small FIFO decouples the field producer from the instruction-memory write port.
- Sits between the testbench/boot loader and instruction memory, ahead of fetch.

Parameters:
- ADDR_W, 6, imem address width; capacity 2**ADDR_W words.
- FIFO_DEPTH, 4, entries in the internal word FIFO; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  pulse; begins a program load at address 0.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- in_last  input  1  marks the final bundle of the program.
- in_reg_mode  input  1  1 = build operands from rs/rt; 0 = use in_a/in_b verbatim.
- in_opcode  input  4  opcode, placed in word bits [19:16].
- in_a  input  8  operand A, placed in bits [15:8] (field mode).
- in_b  input  8  operand B, placed in bits [7:0] (field mode).
- in_rs  input  3  source/destination register, placed in bits [10:8] (reg mode).
- in_rt  input  3  second source register, placed in bits [2:0] (reg mode).
- imem_stall  input  1  memory cannot take a write in the next cycle.
- imem_we  output  1  write strobe, registered.
- imem_addr  output  ADDR_W  write address, registered.
- imem_wdata  output  20  instruction word, registered.
- busy  output  1  high in LOAD and FLUSH.
- done  output  1  one-cycle pulse when a load completes.
- overflow  output  1  sticky; a word was dropped because memory was full.
- word_count  output  ADDR_W+1  words written in the current load; saturates at 2**ADDR_W.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; FIFO empty; address counter 0.
  - All outputs 0, including imem_we, done, overflow and word_count.
  - Reset mid-load abandons the load; no further writes are issued.
- Word packing:
  - Field mode: word = {opcode, A, B}.
  - Reg mode: word = {opcode, 5'b0, rs, 5'b0, rt}.
  - rd is implicit (rd = rs) and has no port.
- FSM: IDLE, LOAD, FLUSH, DONE.
  - IDLE -> LOAD on start: clears the address counter, word_count and overflow.
  - LOAD -> FLUSH on an accepted bundle with in_last=1.
  - FLUSH -> DONE when the FIFO is empty and the output register holds no pending write.
  - DONE -> IDLE after one cycle; done=1 only during DONE.
  - start is ignored outside IDLE.
- Input handshake:
  - in_ready = (state==LOAD) && !fifo_full.
  - A bundle is accepted on an edge where in_valid && in_ready; it is pushed to the FIFO at that edge.
  - in_ready is combinational from state and FIFO level only, never from in_valid.
  - A full FIFO with a same-edge pop still deasserts in_ready; there is no bypass.
- Write issue:
  - At each edge where the FIFO is non-empty and imem_stall=0, the head is popped into the output registers, giving imem_we=1 for the next cycle.
  - Otherwise imem_we=0 for the next cycle.
  - The address counter increments on each pop; imem_addr carries the pre-increment value.
  - Best-case latency: bundle accepted at edge k; imem_we=1 in the cycle following edge k+1.
  - Back-to-back pops sustain one write per cycle.
- Overflow:
  - A pop with word_count == 2**ADDR_W discards the word: no imem_we, overflow set.
  - The address counter does not wrap and word_count holds at 2**ADDR_W.
  - overflow clears only on the next start or on reset.
  - The load still completes normally through FLUSH and DONE.
- imem_stall is sampled only when deciding a pop; a write already issued is always completed.

Decomposition:
- Shared package isa_pkg holds:
  - INSTR_W=20, OPC_W=4, OPERAND_W=8, REG_W=3.
  - Field bit positions (OPC_HI/LO, A_HI/LO, B_HI/LO, RS_LO=8, RT_LO=0).
  - The FSM state enum.
- The ID stage imports the same field positions.
- One sub-module, sync_fifo (parameterised width and depth, push/pop, full/empty flags), instantiated with width INSTR_W.

Test Plan:
- Field-mode load:
  - Stimulus: start, then opcode=4'h1, A=8'hAB, B=8'hCD, in_last=1.
  - Required: one write, wdata=20'h1ABCD at addr 0, then done pulse with word_count=1.
- Reg-mode load:
  - Stimulus: opcode=4'h2, rs=3, rt=5.
  - Required: wdata=20'h20305; feeding it to the ID stage yields rs=3, rt=5, rd=3.
- Backpressure:
  - Stimulus: 6 bundles with imem_stall held high.
  - Required: in_ready drops after 4 accepts and no writes occur; after stall release, 6 consecutive writes at addrs 0..5 in order.
- Overflow (ADDR_W=2):
  - Stimulus: load 5 words.
  - Required: addrs 0..3 written, 5th word dropped, overflow=1, word_count=4, done still pulses.
- Reset mid-load:
  - Stimulus: rst_n low for 1 cycle after 2 accepts.
  - Required: imem_we=0 from the next cycle, state IDLE, word_count=0, start restarts at addr 0.
- Control corner cases:
  - Stimulus: start asserted during LOAD; separately, in_valid asserted in IDLE.
  - Required: both ignored, with in_ready=0 in IDLE.
